// File: rtl/pipe_ctrl_delay.sv
// Control/sideband delay line that runs beside a LATENCY-deep datapath.
// Carries valid, sideband and done with the data and counts beats in flight.
module pipe_ctrl_delay #(
    parameter int LATENCY   = 4,
    parameter int SB_WIDTH  = 2,
    parameter int DONE_MODE = 0,
    parameter int CNT_WIDTH = $clog2(LATENCY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 valid_i,
    input  logic [SB_WIDTH-1:0]  sb_i,
    input  logic                 done_i,
    output logic                 valid_o,
    output logic [SB_WIDTH-1:0]  sb_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] inflight_o
);

    logic [LATENCY-1:0]  valid_tap;
    logic [SB_WIDTH-1:0] sb_tap [LATENCY];
    logic [CNT_WIDTH-1:0] inflight_reg;
    logic [CNT_WIDTH-1:0] inflight_next;
    logic                 pending_w;

    // Sideband is zeroed on entry so idle stages never leak stale flags.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                stage_valid_reg;
        logic [SB_WIDTH-1:0] stage_sb_reg;
        logic                stage_valid_next;
        logic [SB_WIDTH-1:0] stage_sb_next;

        if (gi == 0) begin : g_head
            assign stage_valid_next = valid_i;
            assign stage_sb_next    = valid_i ? sb_i : '0;
        end else begin : g_body
            assign stage_valid_next = valid_tap[gi-1];
            assign stage_sb_next    = sb_tap[gi-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stage_valid_reg <= 1'b0;
                stage_sb_reg    <= '0;
            end else if (flush) begin
                stage_valid_reg <= 1'b0;
                stage_sb_reg    <= '0;
            end else if (en) begin
                stage_valid_reg <= stage_valid_next;
                stage_sb_reg    <= stage_sb_next;
            end
        end

        assign valid_tap[gi] = stage_valid_reg;
        assign sb_tap[gi]    = stage_sb_reg;
    end

    always_comb begin
        inflight_next = inflight_reg + CNT_WIDTH'(valid_i)
                      - CNT_WIDTH'(valid_tap[LATENCY-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= '0;
        end else if (flush) begin
            inflight_reg <= '0;
        end else if (en) begin
            inflight_reg <= inflight_next;
        end
    end

    if (DONE_MODE == 0) begin : g_done_chain
        logic [LATENCY-1:0] done_tap;

        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_done_stage
            logic stage_done_reg;
            logic stage_done_next;

            if (gi == 0) begin : g_head
                assign stage_done_next = done_i;
            end else begin : g_body
                assign stage_done_next = done_tap[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_done_reg <= 1'b0;
                end else if (flush) begin
                    stage_done_reg <= 1'b0;
                end else if (en) begin
                    stage_done_reg <= stage_done_next;
                end
            end

            assign done_tap[gi] = stage_done_reg;
        end

        assign done_o    = done_tap[LATENCY-1];
        assign pending_w = 1'b0;
    end else begin : g_drain
        logic pending_reg;
        logic drain_done_reg;
        logic done_any;
        logic fire;

        // Fire only when nothing is left in the pipe after this edge and
        // nothing new is entering; otherwise remember the request.
        assign done_any = pending_reg | done_i;
        assign fire     = done_any && (inflight_next == '0) && !valid_i;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pending_reg    <= 1'b0;
                drain_done_reg <= 1'b0;
            end else if (flush) begin
                pending_reg    <= 1'b0;
                drain_done_reg <= 1'b0;
            end else if (en) begin
                drain_done_reg <= fire;
                pending_reg    <= done_any & ~fire;
            end
        end

        assign done_o    = drain_done_reg;
        assign pending_w = pending_reg;
    end

    assign valid_o    = valid_tap[LATENCY-1];
    assign sb_o       = sb_tap[LATENCY-1];
    assign inflight_o = inflight_reg;
    assign busy_o     = (inflight_reg != '0) | pending_w;

endmodule
